// File: rtl/feature_vector_streamer.sv
// Buffers one N_FEAT-entry feature vector and streams it out as zero-extended words with index/last tags.
// Optional FEATURE_DOUBLE_BUFFER_EN: two ping-pong banks so filling and sending overlap.
module feature_vector_streamer #(
  parameter int unsigned N_FEAT = 100,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              sof_err,
  output logic [15:0]       frame_cnt
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_sof_err;
  logic [OUT_W-1:0]  r_out_data;
  logic [IDX_W-1:0]  r_out_idx;
  logic [IDX_W-1:0]  r_wr_ptr;
  logic [IDX_W-1:0]  r_rd_ptr;
  logic [15:0]       r_frame_cnt;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_last_xfer;
  logic              w_sof_restart;
  logic              w_fill_done;
  logic [IDX_W-1:0]  w_wr_addr;
  logic [IDX_W-1:0]  w_wr_ptr_nxt;
  logic              w_load;
  logic              w_in_ready_nxt;
  logic [DATA_W-1:0] w_rd_data;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign sof_err   = r_sof_err;
  assign frame_cnt = r_frame_cnt;

  assign w_in_xfer     = in_valid & r_in_ready;
  assign w_out_xfer    = r_out_valid & out_ready;
  assign w_last_xfer   = w_out_xfer & r_out_last;
  // An early start-of-frame drops the partial vector and restarts at entry 0
  assign w_sof_restart = w_in_xfer & in_sof & (r_wr_ptr != '0);
  assign w_fill_done   = w_in_xfer & ~w_sof_restart & (r_wr_ptr == LAST_IDX);
  assign w_wr_addr     = w_sof_restart ? '0 : r_wr_ptr;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    if (w_sof_restart)    w_wr_ptr_nxt = IDX_W'(1);
    else if (w_fill_done) w_wr_ptr_nxt = '0;
    else if (w_in_xfer)   w_wr_ptr_nxt = r_wr_ptr + IDX_W'(1);
  end

`ifdef FEATURE_DOUBLE_BUFFER_EN
  logic [DATA_W-1:0] r_buf [2][N_FEAT];
  logic [1:0]        r_full;
  logic [1:0]        w_full_nxt;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic              w_load_last;

  // A bank is released once its last word has moved into the output register
  assign w_rd_data   = r_buf[r_rd_bank][r_rd_ptr];
  assign w_load      = r_full[r_rd_bank] & (~r_out_valid | out_ready);
  assign w_load_last = w_load & (r_rd_ptr == LAST_IDX);

  always_comb begin
    w_full_nxt = r_full;
    if (w_fill_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_load_last) w_full_nxt[r_rd_bank] = 1'b0;
    w_in_ready_nxt = ~(&w_full_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_fill_done) r_wr_bank <= ~r_wr_bank;
      if (w_load_last) r_rd_bank <= ~r_rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer) r_buf[r_wr_bank][w_wr_addr] <= in_data;
  end
`else
  typedef enum logic {S_FILL, S_SEND} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_buf [N_FEAT];

  assign w_rd_data = r_buf[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_state_nxt;
  end

  // Fill until the vector is complete, then stream it fully before accepting more
  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_in_ready_nxt = 1'b0;
    case (r_state)
      S_FILL: begin
        w_in_ready_nxt = ~w_fill_done;
        if (w_fill_done) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_load = ~r_out_valid | (out_ready & ~r_out_last);
        if (w_last_xfer) begin
          w_state_nxt    = S_FILL;
          w_in_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer) r_buf[w_wr_addr] <= in_data;
  end
`endif

  // Output word register, pointers and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sof_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_sof_err  <= w_sof_restart;
      if (w_last_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= OUT_W'(w_rd_data);
        r_out_idx   <= r_rd_ptr;
        r_out_last  <= (r_rd_ptr == LAST_IDX);
        r_rd_ptr    <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + IDX_W'(1);
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
